music_note_sequencer: RTL and testbench
=======================================

Name: music_note_sequencer

Overview:
- Plays a melody stored in a synchronous note ROM by driving the frequency and amplitude inputs of one signal generator (square, sine, etc.).
- Each note: ROM fetch, then wait for the generator's phase-zero strobe, then linear attack, sustain, linear release, then a silent gap.
- Runs on the 32 kHz audio clock, between the top-level mode/button logic and a generator instance.

Parameters:
- ADDR_W, 6, note ROM address width (64 entries).
- TICKS_PER_UNIT, 1000, clock cycles per duration unit (31.25 ms at 32 kHz).
- AMP_STEP, 8, amplitude change per cycle during attack and release.
- GAP_TICKS, 320, silent cycles between notes.
- ALIGN_TIMEOUT, 64, maximum cycles spent waiting for gen_index_zero.

Ports:
- CLK_32KHz  in  1  audio clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins playback at address 0 when idle.
- stop  in  1  one-cycle pulse; aborts playback gracefully.
- loop_en  in  1  wrap to address 0 at end of melody instead of finishing.
- volume  in  8  target sustain amplitude, sampled at each note load.
- note_addr  out  ADDR_W  ROM address.
- note_data  in  24  ROM word, valid 1 cycle after note_addr.
  - [13:0] frequency in Hz.
  - [21:14] duration in units.
  - [22] rest.
  - [23] end-of-melody.
- gen_index_zero  in  1  generator phase-zero strobe.
- gen_frequency  out  14  generator frequency input.
- gen_amplitude  out  8  generator amplitude input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback finishes or stop completes.

Behaviour:
- Reset is asynchronous, active-low, on CLK_32KHz. During and after reset:
  - state=IDLE.
  - note_addr, gen_frequency, gen_amplitude = 0.
  - busy=0, done=0.
  - All counters = 0.
- States: IDLE, FETCH, LOAD, ALIGN, ATTACK, SUSTAIN, RELEASE, GAP, FINISH.
- IDLE: on start, note_addr<=0, go to FETCH. start is ignored in every other state.
- FETCH: holds the address for one cycle, then goes to LOAD.
- LOAD: note_data is valid and is decoded as follows.
  - End flag set:
    - loop_en=1: note_addr<=0, go to FETCH.
    - loop_en=0: go to FINISH.
  - Duration=0: the entry is skipped; increment the address and go to FETCH.
  - Otherwise:
    - Latch frequency into gen_frequency.
    - Latch target <= rest ? 0 : volume.
    - Load dur_cnt = duration*TICKS_PER_UNIT − 1, in a 20-bit counter.
    - Go to ALIGN.
- ALIGN: waits for gen_index_zero=1 or ALIGN_TIMEOUT cycles, whichever comes first, then goes to ATTACK.
  - dur_cnt does not run in ALIGN.
- Duration counter: decrements once per cycle in ATTACK and SUSTAIN.
- ATTACK: gen_amplitude += AMP_STEP, saturating at target. Goes to SUSTAIN when gen_amplitude reaches target.
  - A rest (target=0) enters SUSTAIN after 1 cycle.
- SUSTAIN: holds gen_amplitude. When dur_cnt reaches 0, go to RELEASE.
  - If dur_cnt hits 0 during ATTACK, go straight to RELEASE.
- RELEASE: gen_amplitude −= AMP_STEP, saturating at 0. At 0, load gap_cnt=GAP_TICKS−1 and go to GAP.
- GAP: gen_amplitude=0; count down gap_cnt. At 0, handle the address:
  - Address below 2^ADDR_W−1: increment note_addr and go to FETCH.
  - Address at 2^ADDR_W−1:
    - loop_en=1: wrap to 0 and go to FETCH.
    - loop_en=0: go to FINISH.
- FINISH: done=1 for one cycle; gen_frequency and gen_amplitude are cleared to 0; go to IDLE.
- stop:
  - In FETCH, LOAD, ALIGN, ATTACK or SUSTAIN: go to RELEASE, with an abort flag set.
  - In RELEASE: release continues, abort flag set.
  - In GAP: go directly to FINISH.
  - With the abort flag set, RELEASE reaching 0 goes to FINISH instead of GAP.
  - stop in the same cycle as start while in IDLE: start wins, stop is ignored.
- gen_frequency changes only in LOAD and FINISH, so it is never updated while amplitude is nonzero.
- Latency: start pulse to the first LOAD is 2 cycles.

Decomposition:
- Shared package music_pkg:
  - note word field positions/widths (FREQ_LSB=0, DUR_LSB=14, REST_BIT=22, END_BIT=23).
  - state enum seq_state_t.
  - CLK_HZ=32000.
- Sub-module amp_ramp: saturating up/down ramp.
  - Inputs: step, target, up/down, enable.
  - Output: 8-bit amplitude register and an at_target flag.
  - Used for ATTACK and RELEASE.

Test Plan:
- Single note:
  - ROM[0]={freq=440, dur=2}, ROM[1]=end, loop_en=0, volume=200, start.
  - Expect: gen_frequency=440 two cycles after start; amplitude ramps 8,16…200 (25 steps).
  - Expect: RELEASE begins 2000 cycles after ATTACK entry; amplitude reaches 0 after 25 steps.
  - Expect: GAP lasts 320 cycles; done pulses once; busy=0.
- Alignment:
  - Hold gen_index_zero=0 for 10 cycles, then pulse it: ATTACK starts the cycle after the pulse.
  - Hold gen_index_zero=0 permanently: ATTACK starts after 64 cycles.
- Rest and skip:
  - ROM[0]={rest, dur=1}: gen_amplitude stays 0 for the whole note.
  - ROM[1]={dur=0}: skipped with no ALIGN entered.
  - ROM[2]=end.
- Stop mid-sustain:
  - stop at cycle 500 of a volume=255 note: amplitude ramps down to 0 in 32 cycles.
  - done is asserted; no GAP is entered; gen_frequency=0 afterwards.
- Loop:
  - loop_en=1, ROM[0]=note, ROM[1]=end: note_addr returns to 0 and the note replays.
  - Deassert loop_en: done after the next end.
- Reset mid-ATTACK:
  - Assert reset_n=0 asynchronously: all outputs are 0 immediately.
  - Release reset: state is IDLE, and a new start works.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the note sequencer: note word layout, sequencer
// state encoding and the audio clock rate.
package music_pkg;

   localparam int CLK_HZ   = 32000;

   // Note ROM word layout
   localparam int NOTE_W   = 24;
   localparam int FREQ_LSB = 0;
   localparam int FREQ_W   = 14;
   localparam int DUR_LSB  = 14;
   localparam int DUR_W    = 8;
   localparam int REST_BIT = 22;
   localparam int END_BIT  = 23;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_LOAD    = 4'd2,
      S_ALIGN   = 4'd3,
      S_ATTACK  = 4'd4,
      S_SUSTAIN = 4'd5,
      S_RELEASE = 4'd6,
      S_GAP     = 4'd7,
      S_FINISH  = 4'd8
   } seq_state_t;

endpackage

// File: rtl/amp_ramp.sv
// Saturating linear amplitude ramp.
// Ports:
//   CLK_32KHz, reset_n : clock, async active-low reset
//   step               : change per enabled cycle
//   target             : upper limit when ramping up (down always ends at 0)
//   up                 : 1 = ramp toward target, 0 = ramp toward 0
//   en                 : apply one step this cycle
//   clr                : force amplitude to 0
//   amp                : amplitude register
//   at_target          : the step taken this cycle lands on the limit
module amp_ramp #(
   parameter int W = 8
)(
   input  logic         CLK_32KHz,
   input  logic         reset_n,
   input  logic [W-1:0] step,
   input  logic [W-1:0] target,
   input  logic         up,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] amp,
   output logic         at_target
);

   logic [W:0]   sum;
   logic [W-1:0] amp_nxt;

   always_comb begin
      sum = {1'b0, amp} + {1'b0, step};
      if (up) amp_nxt = (sum >= {1'b0, target}) ? target : sum[W-1:0];
      else    amp_nxt = (amp > step) ? (amp - step) : '0;
   end

   // Looks at the next value so the FSM leaves the ramp state on the same
   // edge the limit is reached.
   assign at_target = up ? (amp_nxt == target) : (amp_nxt == '0);

   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n)  amp <= '0;
      else if (clr)  amp <= '0;
      else if (en)   amp <= amp_nxt;
   end

endmodule

// File: rtl/music_note_sequencer.sv
// Melody sequencer: walks a synchronous note ROM and drives one signal
// generator's frequency/amplitude with attack/sustain/release envelopes.
// Ports:
//   CLK_32KHz, reset_n  : audio clock, async active-low reset
//   start, stop         : one-cycle control pulses
//   loop_en             : wrap to address 0 at end of melody
//   volume              : sustain amplitude, sampled when a note is loaded
//   note_addr/note_data : ROM address out, ROM word in (1 cycle later)
//   gen_index_zero      : generator phase-zero strobe
//   gen_frequency/gen_amplitude : generator controls
//   busy, done          : not idle / one-cycle completion pulse
module music_note_sequencer #(
   parameter int ADDR_W         = 6,
   parameter int TICKS_PER_UNIT = 1000,
   parameter int AMP_STEP       = 8,
   parameter int GAP_TICKS      = 320,
   parameter int ALIGN_TIMEOUT  = 64
)(
   input  logic              CLK_32KHz,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [7:0]        volume,
   output logic [ADDR_W-1:0] note_addr,
   input  logic [23:0]       note_data,
   input  logic              gen_index_zero,
   output logic [13:0]       gen_frequency,
   output logic [7:0]        gen_amplitude,
   output logic              busy,
   output logic              done
);
   import music_pkg::*;

   localparam int AW = $clog2(ALIGN_TIMEOUT);
   localparam int GW = $clog2(GAP_TICKS);

   seq_state_t        state;
   logic [7:0]        target;
   logic [19:0]       dur_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [AW-1:0]     align_cnt;
   logic              abort;
   logic              ramp_en, ramp_up, ramp_clr, ramp_at;

   logic [FREQ_W-1:0] nd_freq;
   logic [DUR_W-1:0]  nd_dur;
   logic              nd_rest, nd_end;

   assign nd_freq = note_data[FREQ_LSB +: FREQ_W];
   assign nd_dur  = note_data[DUR_LSB +: DUR_W];
   assign nd_rest = note_data[REST_BIT];
   assign nd_end  = note_data[END_BIT];

   assign busy = (state != S_IDLE);
   assign done = (state == S_FINISH);

   // A stop during attack freezes the ramp; release starts from there.
   assign ramp_up  = (state == S_ATTACK);
   assign ramp_en  = ((state == S_ATTACK) && !stop) || (state == S_RELEASE);
   assign ramp_clr = (state == S_FINISH);

   amp_ramp #(.W(8)) u_ramp (
      .CLK_32KHz (CLK_32KHz),
      .reset_n   (reset_n),
      .step      (8'(AMP_STEP)),
      .target    (target),
      .up        (ramp_up),
      .en        (ramp_en),
      .clr       (ramp_clr),
      .amp       (gen_amplitude),
      .at_target (ramp_at)
   );

   always_ff @(posedge CLK_32KHz or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         note_addr     <= '0;
         gen_frequency <= '0;
         target        <= '0;
         dur_cnt       <= '0;
         gap_cnt       <= '0;
         align_cnt     <= '0;
         abort         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               note_addr <= '0;
               abort     <= 1'b0;
               state     <= S_FETCH;
            end
            S_FETCH: begin
               if (stop) begin state <= S_RELEASE; abort <= 1'b1; end
               else           state <= S_LOAD;
            end
            S_LOAD: begin
               if (stop) begin
                  state <= S_RELEASE; abort <= 1'b1;
               end else if (nd_end) begin
                  if (loop_en) begin note_addr <= '0; state <= S_FETCH; end
                  else           state <= S_FINISH;
               end else if (nd_dur == '0) begin
                  note_addr <= note_addr + 1'b1;
                  state     <= S_FETCH;
               end else begin
                  gen_frequency <= nd_freq;
                  target        <= nd_rest ? 8'd0 : volume;
                  dur_cnt       <= 20'(nd_dur) * 20'(TICKS_PER_UNIT) - 20'd1;
                  align_cnt     <= '0;
                  state         <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (stop) begin
                  state <= S_RELEASE; abort <= 1'b1; align_cnt <= '0;
               end else if (gen_index_zero || align_cnt == AW'(ALIGN_TIMEOUT - 1)) begin
                  state <= S_ATTACK; align_cnt <= '0;
               end else begin
                  align_cnt <= align_cnt + 1'b1;
               end
            end
            S_ATTACK: begin
               if (stop) begin
                  state <= S_RELEASE; abort <= 1'b1;
               end else if (dur_cnt == '0) begin
                  state <= S_RELEASE;
               end else begin
                  dur_cnt <= dur_cnt - 20'd1;
                  if (ramp_at) state <= S_SUSTAIN;
               end
            end
            S_SUSTAIN: begin
               if (stop) begin state <= S_RELEASE; abort <= 1'b1; end
               else if (dur_cnt == '0) state <= S_RELEASE;
               else dur_cnt <= dur_cnt - 20'd1;
            end
            S_RELEASE: begin
               if (stop) abort <= 1'b1;
               if (ramp_at) begin
                  if (abort || stop) state <= S_FINISH;
                  else begin
                     gap_cnt <= GW'(GAP_TICKS - 1);
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (stop) begin
                  gap_cnt <= '0; state <= S_FINISH;
               end else if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (note_addr != '1) begin
                  note_addr <= note_addr + 1'b1; state <= S_FETCH;
               end else if (loop_en) begin
                  note_addr <= '0; state <= S_FETCH;
               end else begin
                  state <= S_FINISH;
               end
            end
            S_FINISH: begin
               gen_frequency <= '0;
               abort         <= 1'b0;
               dur_cnt       <= '0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_music_note_sequencer.sv
module tb_music_note_sequencer;

   logic        clk, reset_n, start, stop, loop_en, gen_index_zero;
   logic [7:0]  volume, gen_amplitude;
   logic [5:0]  note_addr;
   logic [23:0] note_data;
   logic [13:0] gen_frequency;
   logic        busy, done;

   music_note_sequencer dut (
      .CLK_32KHz      (clk),
      .reset_n        (reset_n),
      .start          (start),
      .stop           (stop),
      .loop_en        (loop_en),
      .volume         (volume),
      .note_addr      (note_addr),
      .note_data      (note_data),
      .gen_index_zero (gen_index_zero),
      .gen_frequency  (gen_frequency),
      .gen_amplitude  (gen_amplitude),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] rom [64];
   always @(posedge clk) note_data <= rom[note_addr];

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Scenario knobs used by the reference model and the driver
   int vol, gper, gph, loop_off, stop_mode, stop_at, stop_n;
   bit loop_base;

   typedef struct { int addr; int freq; int amp; int busy; int done; } exp_t;
   exp_t exp_q[$];

   function automatic logic [23:0] mk(int f, int d, bit r, bit e);
      logic [23:0] w;
      w = {e, r, 8'(d), 14'(f)};
      return w;
   endfunction

   function automatic bit giz(int n);
      return (gper != 0) && ((n % gper) == gph);
   endfunction

   function automatic bit lp(int n);
      return loop_base && (n < loop_off);
   endfunction

   task automatic push(int a, int f, int amp, int b, int d);
      exp_t e;
      e.addr = a; e.freq = f; e.amp = amp; e.busy = b; e.done = d;
      exp_q.push_back(e);
   endtask

   // Expected per-cycle output trace, cycle 0 = first cycle after start is taken.
   task automatic build_model();
      int n, a, f, amp, tgt, nb;
      bit fin, stopped;
      logic [23:0] w;
      exp_q.delete();
      stop_n = -1;
      n = 0; a = 0; f = 0; fin = 0;
      while (!fin && n < 60000) begin
         push(a, f, 0, 1, 0); n++;          // fetch
         push(a, f, 0, 1, 0); n++;          // load
         w = rom[a];
         if (w[23]) begin
            if (lp(n-1)) a = 0; else fin = 1;
            continue;
         end
         if (w[21:14] == 0) begin a = (a + 1) % 64; continue; end
         f   = int'(w[13:0]);
         tgt = w[22] ? 0 : vol;
         nb  = int'(w[21:14]) * 1000;
         for (int k = 0; ; k++) begin
            push(a, f, 0, 1, 0); n++;
            if (giz(n-1) || k == 63) break;
         end
         stopped = 0;
         amp = tgt;
         for (int i = 0; i < nb; i++) begin
            amp = (8*i < tgt) ? 8*i : tgt;
            push(a, f, amp, 1, 0); n++;
            if (stop_mode == 1 && stop_n < 0 && i == stop_at) begin
               stop_n = n-1; stopped = 1; break;
            end
            amp = tgt;
         end
         forever begin
            push(a, f, amp, 1, 0); n++;
            amp = (amp > 8) ? amp - 8 : 0;
            if (amp == 0) break;
         end
         if (stopped) begin fin = 1; continue; end
         for (int j = 0; j < 320; j++) begin
            push(a, f, 0, 1, 0); n++;
            if (stop_mode == 2 && stop_n < 0 && j == stop_at) begin
               stop_n = n-1; stopped = 1; break;
            end
         end
         if (stopped) begin fin = 1; continue; end
         if (a < 63) a++;
         else if (lp(n-1)) a = 0;
         else fin = 1;
      end
      push(a, f, 0, 1, 1);                  // finish
      push(a, 0, 0, 0, 0);                  // back to idle
   endtask

   task automatic run_trace(input string tag);
      int len, f0;
      build_model();
      len = exp_q.size();
      @(negedge clk);
      volume = 8'(vol);
      start = 1'b1;
      stop = 1'($urandom_range(0, 1));      // start must win over stop in idle
      loop_en = lp(0);
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         f0 = n_fail;
         chk({tag, ".addr"}, 32'(note_addr),     exp_q[n].addr);
         chk({tag, ".freq"}, 32'(gen_frequency), exp_q[n].freq);
         chk({tag, ".amp"},  32'(gen_amplitude), exp_q[n].amp);
         chk({tag, ".busy"}, 32'(busy),          exp_q[n].busy);
         chk({tag, ".done"}, 32'(done),          exp_q[n].done);
         if (n_fail != f0) begin
            $display("  at cycle %0d of %s", n, tag);
            break;
         end
         start = (exp_q[n].busy == 1) && ($urandom_range(0, 7) == 0);
         stop = (n == stop_n);
         gen_index_zero = giz(n);
         loop_en = lp(n);
      end
      start = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic set_defaults();
      for (int i = 0; i < 64; i++) rom[i] = mk(0, 0, 0, 1);
      vol = 200; gper = 17; gph = 5; loop_base = 0; loop_off = 0;
      stop_mode = 0; stop_at = 0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      volume = 8'd0; gen_index_zero = 1'b0;
      set_defaults();
      #12;
      chk("rst.addr", 32'(note_addr), 0);
      chk("rst.freq", 32'(gen_frequency), 0);
      chk("rst.amp",  32'(gen_amplitude), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle.busy", 32'(busy), 0);

      // single note
      rom[0] = mk(440, 2, 0, 0);
      run_trace("single");

      // alignment: pulse after 10 idle align cycles, then never
      set_defaults(); rom[0] = mk(1000, 1, 0, 0);
      gper = 5000; gph = 12;
      run_trace("align_pulse");
      gper = 0;
      run_trace("align_timeout");

      // rest and skip
      set_defaults();
      rom[0] = mk(700, 1, 1, 0); rom[1] = mk(900, 0, 0, 0);
      run_trace("rest_skip");

      // stop mid-sustain / in gap
      set_defaults(); rom[0] = mk(523, 2, 0, 0); rom[1] = mk(659, 1, 0, 0);
      vol = 255; stop_mode = 1; stop_at = 500;
      run_trace("stop_sustain");
      stop_mode = 2; stop_at = 100;
      run_trace("stop_gap");

      // loop, then loop_en dropped
      set_defaults(); rom[0] = mk(330, 1, 0, 0);
      loop_base = 1; loop_off = 4000;
      run_trace("loop");

      // top address: gap at 63 ends the melody
      set_defaults();
      for (int i = 0; i < 62; i++) rom[i] = mk(i, 0, 0, 0);
      rom[62] = mk(300, 1, 0, 0); rom[63] = mk(500, 1, 0, 0);
      run_trace("addr_top");

      // random melodies
      for (int r = 0; r < 3; r++) begin
         int nn;
         set_defaults();
         nn = $urandom_range(1, 3);
         for (int i = 0; i < nn; i++)
            rom[i] = mk($urandom_range(1, 16383),
                        ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 2),
                        1'($urandom_range(0, 3) == 0), 1'b0);
         vol  = $urandom_range(1, 255);
         gper = $urandom_range(0, 80);
         gph  = (gper == 0) ? 0 : $urandom_range(0, gper - 1);
         run_trace("random");
      end

      // reset during attack
      set_defaults(); rom[0] = mk(440, 2, 0, 0); vol = 100;
      @(negedge clk);
      volume = 8'd100; gen_index_zero = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 300 && gen_amplitude == 0; c++) @(negedge clk);
      chk("rst_mid.attack_seen", 32'(gen_amplitude != 0), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid.addr", 32'(note_addr), 0);
      chk("rst_mid.freq", 32'(gen_frequency), 0);
      chk("rst_mid.amp",  32'(gen_amplitude), 0);
      chk("rst_mid.busy", 32'(busy), 0);
      chk("rst_mid.done", 32'(done), 0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mid.idle", 32'(busy), 0);
      run_trace("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
